// File: rtl/aes_pkg.sv
// Shared types and constants for the AES ciphertext byte streamer.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int BYTE_W      = 8;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/aes_ct_streamer_latency_counter.sv
// Loadable down-counter that times the AES core latency; flags when it reads zero.
module latency_counter
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/aes_ct_streamer.sv
// Waits out the AES core latency, captures the ciphertext block for the RAM,
// then streams it MSB byte first over a valid/ready handshake.
module aes_ct_streamer
    import aes_pkg::*;
#(
    parameter int LATENCY = 21,
    parameter int NBYTES  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [AES_BLOCK_W-1:0] ciphertext,
    output logic [BYTE_W-1:0]      byte_data,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   busy,
    output logic                   done,
    output logic [AES_BLOCK_W-1:0] block_q,
    output logic                   block_we
);

    localparam int IDX_W = $clog2(NBYTES);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [AES_BLOCK_W-1:0] r_block_q;
    logic                   r_block_we;
    logic [IDX_W-1:0]       r_idx;
    logic [AES_BLOCK_W-1:0] w_shifted;
    logic                   w_load;
    logic                   w_cnt_zero;
    logic                   w_capture;
    logic                   w_accept;
    logic                   w_last;

    assign w_load    = (r_state == IDLE) && start;
    assign w_capture = (r_state == WAIT) && w_cnt_zero;
    assign w_accept  = (r_state == SEND) && byte_ready;
    assign w_last    = w_accept && (r_idx == IDX_W'(NBYTES - 1));
    assign w_shifted = r_block_q << (BYTE_W * int'(r_idx));

    latency_counter u_latency_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (CNT_W'(LATENCY - 1)),
        .i_dec      (r_state == WAIT),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        byte_valid  = 1'b0;
        byte_data   = '0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = WAIT;
            end
            WAIT: begin
                if (w_cnt_zero) w_state_nxt = SEND;
            end
            SEND: begin
                byte_valid = 1'b1;
                byte_data  = w_shifted[AES_BLOCK_W-1 -: BYTE_W];
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The captured block stays put until the next capture so the RAM sees stable data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_block_q  <= '0;
            r_block_we <= 1'b0;
            r_idx      <= '0;
        end else begin
            r_block_we <= w_capture;
            if (w_capture) begin
                r_block_q <= ciphertext;
                r_idx     <= '0;
            end else if (w_accept) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign block_q  = r_block_q;
    assign block_we = r_block_we;

endmodule

// File: tb/tb_aes_ct_streamer.sv
// Directed bench for aes_ct_streamer with a behavioural AES-128 model standing in for the core.
module tb_aes_ct_streamer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         start1 = 1'b0;
    logic         byte_ready = 1'b0;
    logic         ready1 = 1'b0;
    logic [127:0] ciphertext = '0;

    logic [7:0]   byte_data, byte_data1;
    logic         byte_valid, byte_valid1;
    logic         busy, busy1;
    logic         done, done1;
    logic [127:0] block_q, block_q1;
    logic         block_we, block_we1;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] JUNK   = 128'hdeadbeef_cafef00d_0badc0de_55aa55aa;
    localparam logic [127:0] CT_SEQ = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] CT2    = 128'h11223344_55667788_99aabbcc_ddeeff00;
    localparam logic [127:0] CT3    = 128'hf0e1d2c3_b4a59687_78695a4b_3c2d1e0f;
    localparam logic [127:0] CT6    = 128'ha1b2c3d4_e5f60718_293a4b5c_6d7e8f90;

    aes_ct_streamer #(.LATENCY(21), .NBYTES(16)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ciphertext (ciphertext),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .done       (done),
        .block_q    (block_q),
        .block_we   (block_we)
    );

    aes_ct_streamer #(.LATENCY(1), .NBYTES(16)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start1),
        .ciphertext (ciphertext),
        .byte_data  (byte_data1),
        .byte_valid (byte_valid1),
        .byte_ready (ready1),
        .busy       (busy1),
        .done       (done1),
        .block_q    (block_q1),
        .block_we   (block_we1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // ---------------- behavioural AES-128 ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        logic [7:0] p = x;
        for (int k = 1; k < 8; k++) begin
            p   = gm(p, p);
            inv = gm(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc = 8'h01;
        logic [31:0]  tmp;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb(s[i]);
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    s[rr+4*c] = t[rr+4*((c+rr)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
        return v[127-8*i -: 8];
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_block_q"}, block_q, '0);
        chk({tag, "_outs"}, {byte_valid, byte_data, busy, done, block_we}, '0);
    endtask

    // Full block with byte_ready held high on the LATENCY=21 instance.
    task automatic run_block(input logic [127:0] ct, input string tag);
        int n;
        ciphertext = ct;
        byte_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!block_we && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 22);
        for (int i = 0; i < 16; i++) begin
            chk({tag, "_byte"}, {byte_valid, byte_data}, {1'b1, byte_of(ct, i)});
            chk({tag, "_no_early_done"}, done, 1'b0);
            tick();
        end
        chk({tag, "_done"}, {done, byte_valid}, 2'b10);
        chk({tag, "_block_q"}, block_q, ct);
        tick();
        chk({tag, "_idle_after"}, {busy, done}, 2'b00);
    endtask

    // Idle window after an aborted block: no late strobe or done may appear.
    task automatic quiet_window(input string tag);
        for (int i = 0; i < 30; i++) begin
            chk({tag, "_quiet"}, {busy, block_we, done}, 3'b000);
            tick();
        end
    endtask

    typedef struct {
        int         cyc;
        logic       busy;
        logic       we;
        logic       vld;
        logic [7:0] data;
        logic       done;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int idx;
        int cyc;
        int ndone;
        logic [127:0] ct_aes;

        tbl[0] = '{1,  1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{20, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{21, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{22, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0};
        tbl[4] = '{23, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0};
        tbl[5] = '{30, 1'b1, 1'b0, 1'b1, 8'h08, 1'b0};
        tbl[6] = '{37, 1'b1, 1'b0, 1'b1, 8'h0f, 1'b0};
        tbl[7] = '{38, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[8] = '{39, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

        // Reset state
        ciphertext = JUNK;
        tick();
        tick();
        chk_zero("reset");
        chk("reset_inst1", {block_q1, byte_valid1, byte_data1, busy1, done1, block_we1}, '0);

        // Basic block: start with reset release, ciphertext valid only in the capture cycle
        rst_n = 1'b1;
        byte_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 39; c++) begin
            ciphertext = (c == 21) ? CT_SEQ : JUNK;
            for (int k = 0; k < 9; k++) begin
                if (tbl[k].cyc == c)
                    chk($sformatf("basic_c%0d", c), {busy, block_we, byte_valid, byte_data, done},
                        {tbl[k].busy, tbl[k].we, tbl[k].vld, tbl[k].data, tbl[k].done});
            end
            if (c == 22) chk("basic_block_q", block_q, CT_SEQ);
            if (c == 39) chk("basic_block_q_held", block_q, CT_SEQ);
            tick();
        end

        // byte_ready toggling: each byte held while stalled
        ciphertext = CT2;
        byte_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!byte_valid && cyc < 300) begin
            tick();
            cyc++;
        end
        chk("stall_reached_send", byte_valid, 1'b1);
        idx = 0;
        cyc = 0;
        while (idx < 16 && cyc < 100) begin
            byte_ready = (cyc % 2 == 1);
            chk($sformatf("stall_byte%0d", idx), {byte_valid, byte_data}, {1'b1, byte_of(CT2, idx)});
            chk("stall_no_early_done", done, 1'b0);
            if (byte_ready) idx++;
            tick();
            cyc++;
        end
        byte_ready = 1'b1;
        chk("stall_count", idx, 16);
        chk("stall_done", {done, byte_valid}, 2'b10);
        tick();

        // Extra start pulses during WAIT and SEND are ignored
        ciphertext = CT3;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 45; c++) begin
            start = (c == 5) || (c == 25);
            chk($sformatf("ignore_c%0d", c), {busy, done}, {(c <= 38), (c == 38)});
            if (done) ndone++;
            tick();
        end
        start = 1'b0;
        chk("ignore_one_done", ndone, 1);

        // Reset at cycle 10 of WAIT
        ciphertext = CT2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        chk("wait_busy_before_rst", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk_zero("rst_wait");
        tick();
        rst_n = 1'b1;
        quiet_window("rst_wait");
        run_block(CT3, "after_rst_wait");

        // Reset at byte 5 of SEND
        ciphertext = CT2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 27; c++) tick();
        chk("send_byte5_before_rst", {byte_valid, byte_data}, {1'b1, byte_of(CT2, 5)});
        #1 rst_n = 1'b0;
        #1 chk_zero("rst_send");
        tick();
        rst_n = 1'b1;
        quiet_window("rst_send");
        run_block(CT_SEQ, "after_rst_send");

        // Group-2 AES vector through the behavioural core
        chk("aes_model_kat", aes_enc(128'h3243f6a8885a308d313198a2e0370734,
                                     128'h2b7e151628aed2a6abf7158809cf4f3c),
            128'h3925841d02dc09fbdc118597196a0b32);
        ct_aes = aes_enc(128'h97157a6fc8e4bbe432c40d35f2716092,
                         128'heba02e379817d636a144551df49ade37);
        run_block(ct_aes, "aes_g2");

        // LATENCY=1 instance: capture on the edge after start, back-to-back restart
        ciphertext = JUNK;
        ready1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        ciphertext = CT6;
        chk("lat1_c1", {busy1, block_we1, byte_valid1}, 3'b100);
        tick();
        ciphertext = JUNK;
        chk("lat1_capture", {block_we1, block_q1}, {1'b1, CT6});
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("lat1_byte%0d", i), {byte_valid1, byte_data1}, {1'b1, byte_of(CT6, i)});
            tick();
        end
        chk("lat1_done", {done1, busy1}, 2'b11);
        start1 = 1'b1;
        tick();
        chk("lat1_start_in_done_ignored", {busy1, done1}, 2'b00);
        tick();
        start1 = 1'b0;
        chk("lat1_restart", {busy1, block_we1}, 2'b10);
        tick();
        chk("lat1_restart_we", {block_we1, byte_valid1}, 2'b11);
        cyc = 0;
        while (!done1 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("lat1_second_done", done1, 1'b1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_ct_streamer.md
AES_CT_STREAMER -- requirements
Module: aes_ct_streamer

Interface — parameters
REQ-001 SHALL have parameter LATENCY, default 21, cycles from start to valid ciphertext at aes_128 out; legal range 1..255.
REQ-002 SHALL have parameter NBYTES, default 16, bytes per ciphertext block (128/8).

Interface — ports
REQ-003 SHALL have port clk, input, 1, single clock for all state.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle pulse: state/key were applied to aes_128 this cycle.
REQ-006 SHALL have port ciphertext, input, 128, aes_128 out bus.
REQ-007 SHALL have port byte_data, output, 8, current output byte.
REQ-008 SHALL have port byte_valid, output, 1, byte_data valid.
REQ-009 SHALL have port byte_ready, input, 1, consumer accepts byte.
REQ-010 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle pulse after the last byte is accepted.
REQ-012 SHALL have port block_q, output, 128, captured ciphertext, for RAM write data.
REQ-013 SHALL have port block_we, output, 1, one-cycle RAM write strobe on capture.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, SEND, DONE.
REQ-015 IDLE: start=1 SHALL go to WAIT and load the latency counter with LATENCY-1.
REQ-016 WAIT: the counter SHALL decrement each cycle; on the edge it reads 0, ciphertext SHALL be captured into block_q, block_we SHALL pulse the following cycle, and the FSM SHALL go to SEND.
REQ-017 Capture SHALL occur exactly LATENCY rising edges after the edge that sampled start.
REQ-018 SEND: byte_valid SHALL be 1 and byte_data SHALL equal the indexed byte of block_q, MSB first (byte 0 = block_q[127:120]).
REQ-019 The byte index SHALL advance only on byte_valid && byte_ready.
REQ-020 byte_data SHALL remain stable while byte_valid=1 and byte_ready=0.
REQ-021 Acceptance of byte NBYTES-1 SHALL move to DONE.
REQ-022 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-023 start SHALL be ignored in WAIT, SEND and DONE (no restart, no queueing).
REQ-024 start in the same cycle the FSM enters IDLE from DONE SHALL be ignored; it is sampled only while in IDLE.
REQ-025 byte_ready held 1 SHALL yield one byte per cycle: 16 consecutive valid cycles.
REQ-026 block_q SHALL hold its value until the next capture.
REQ-027 The byte index SHALL be $clog2(NBYTES) bits wide and SHALL reset to 0 on entry to SEND.
REQ-028 The latency counter SHALL be 8 bits wide.

Reset
REQ-029 rst_n=0 SHALL asynchronously force: FSM=IDLE, counter=0, index=0, block_q=0, byte_valid=0, byte_data=0, busy=0, done=0, block_we=0.
REQ-030 Reset mid-WAIT or mid-SEND SHALL abandon the block; no partial done and no block_we pulse SHALL follow.
REQ-031 Release of rst_n SHALL take effect synchronously; the first start SHALL be honoured on the first edge after release.

Structure
REQ-032 The state enumeration and the constants AES_BLOCK_W=128 and BYTE_W=8 SHALL live in the shared package aes_pkg.
REQ-033 SHALL contain one sub-module, latency_counter (load, decrement, zero flag); all else SHALL be inline.
REQ-034 The block SHALL sit between aes_128.out and the 1-word RAM: block_q drives data and block_we drives wren.

Verification
REQ-035 Bench SHALL cover: LATENCY=21, start at cycle 0, ciphertext=0x000102...0F, byte_ready=1 -> capture at edge 21, block_we at 22, bytes 0x00..0x0F on cycles 22..37, done at 38.
REQ-036 Bench SHALL cover: byte_ready toggling 1/0 -> each byte held stable while stalled, 16 distinct bytes in order, done only after byte 0x0F is accepted.
REQ-037 Bench SHALL cover: second start pulse during WAIT and during SEND -> ignored, busy unaffected, exactly one done.
REQ-038 Bench SHALL cover: rst_n low at cycle 10 of WAIT and at byte 5 of SEND -> all outputs 0 immediately, no done/block_we, next start runs a full clean block.
REQ-039 Bench SHALL cover: group-2 vector state=97157a6fc8e4bbe432c40d35f2716092, key=eba02e379817d636a144551df49ade37 via aes_128 -> streamed bytes equal the golden AES-128 ciphertext and block_q equals the RAM content.
REQ-040 Bench SHALL cover: LATENCY=1 -> capture on the edge after start; back-to-back start on the cycle after done is honoured.
